// File: rtl/lcd_char_refresh.sv
// HD44780 character-LCD controller: timed power-up init, then continuous refresh
// of a writable ROWS x COLS character buffer with steady, blink and blank modes.
module lcd_char_refresh #(
    parameter int unsigned STEP_CYCLES   = 2000,
    parameter int unsigned POWERUP_TICKS = 1000,
    parameter int unsigned CLEAR_TICKS   = 50,
    parameter int unsigned COLS          = 16,
    parameter int unsigned ROWS          = 2,
    parameter int unsigned BLINK_FRAMES  = 8,
    localparam int unsigned AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [1:0]    mode,
    output logic          ready,
    output logic          frame_done,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_dat,
    output logic          LCD_N,
    output logic          LCD_P
);

    localparam int unsigned NCELL = ROWS * COLS;
    localparam int unsigned TW    = $clog2(STEP_CYCLES);
    localparam int unsigned WMAX  = (POWERUP_TICKS > CLEAR_TICKS) ? POWERUP_TICKS : CLEAR_TICKS;
    localparam int unsigned WW    = $clog2(WMAX + 1);
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [2:0] {
        PWR_WAIT,
        CMD,
        CLR_WAIT,
        ROW_ADDR,
        ROW_DATA,
        FRAME_END
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [1:0]      bph;
    logic [WW-1:0]   wait_cnt;
    logic [1:0]      cmd_idx;
    logic            row;
    logic [CW-1:0]   col;
    logic [FW-1:0]   fcnt;
    logic            blink_ph;
    logic            blank;
    logic [7:0]      cells [NCELL];

    logic [AW-1:0]   cell_idx;
    logic            sel_rs;
    logic [7:0]      sel_dat;
    logic            blank_nx;
    logic            ph_nx;
    logic [FW-1:0]   fcnt_nx;

    assign lcd_rw = 1'b0;
    assign LCD_N  = 1'b0;
    assign LCD_P  = 1'b1;

    // One-clk tick every STEP_CYCLES clocks paces all panel activity
    assign tick = (tick_cnt == TW'(STEP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Character buffer; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCELL; i++)
                cells[i] <= 8'h20;
        end else if (wr_en && (32'(wr_addr) < NCELL)) begin
            cells[wr_addr] <= wr_data;
        end
    end

    assign cell_idx = row ? (AW'(COLS) + AW'(col)) : AW'(col);

    // Byte presented at the next SETUP tick
    always_comb begin
        sel_rs  = 1'b0;
        sel_dat = 8'h00;
        case (state)
            CMD: begin
                case (cmd_idx)
                    2'd0:    sel_dat = 8'h38;
                    2'd1:    sel_dat = 8'h0C;
                    2'd2:    sel_dat = 8'h06;
                    default: sel_dat = 8'h01;
                endcase
            end
            ROW_ADDR: sel_dat = row ? 8'hC0 : 8'h80;
            ROW_DATA: begin
                sel_rs  = 1'b1;
                sel_dat = blank ? 8'h20 : cells[cell_idx];
            end
            default: ;
        endcase
    end

    // Blink bookkeeping applied once per frame when row 0 is entered
    always_comb begin
        blank_nx = (mode == 2'b10);
        ph_nx    = 1'b0;
        fcnt_nx  = '0;
        if (mode == 2'b01) begin
            blank_nx = blink_ph;
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt_nx = '0;
                ph_nx   = ~blink_ph;
            end else begin
                fcnt_nx = fcnt + 1'b1;
                ph_nx   = blink_ph;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PWR_WAIT;
            bph        <= 2'd0;
            wait_cnt   <= '0;
            cmd_idx    <= 2'd0;
            row        <= 1'b0;
            col        <= '0;
            fcnt       <= '0;
            blink_ph   <= 1'b0;
            blank      <= 1'b0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_dat    <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            if (state == FRAME_END) begin
                // Never a tick edge, so the frame boundary costs no tick
                frame_done <= 1'b1;
                state      <= ROW_ADDR;
                row        <= 1'b0;
                blank      <= blank_nx;
                blink_ph   <= ph_nx;
                fcnt       <= fcnt_nx;
            end else if (tick) begin
                case (state)
                    PWR_WAIT: begin
                        if (wait_cnt == WW'(POWERUP_TICKS - 1)) begin
                            wait_cnt <= '0;
                            cmd_idx  <= 2'd0;
                            state    <= CMD;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    CLR_WAIT: begin
                        if (wait_cnt == WW'(CLEAR_TICKS - 1)) begin
                            wait_cnt <= '0;
                            ready    <= 1'b1;
                            state    <= ROW_ADDR;
                            row      <= 1'b0;
                            blank    <= blank_nx;
                            blink_ph <= ph_nx;
                            fcnt     <= fcnt_nx;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // SETUP / PULSE / HOLD of one byte, then advance
                        case (bph)
                            2'd0: begin
                                lcd_rs  <= sel_rs;
                                lcd_dat <= sel_dat;
                                lcd_en  <= 1'b0;
                                bph     <= 2'd1;
                            end
                            2'd1: begin
                                lcd_en <= 1'b1;
                                bph    <= 2'd2;
                            end
                            default: begin
                                lcd_en <= 1'b0;
                                bph    <= 2'd0;
                                case (state)
                                    CMD: begin
                                        if (cmd_idx == 2'd3)
                                            state <= CLR_WAIT;
                                        else
                                            cmd_idx <= cmd_idx + 1'b1;
                                    end
                                    ROW_ADDR: begin
                                        col   <= '0;
                                        state <= ROW_DATA;
                                    end
                                    default: begin
                                        if (col == CW'(COLS - 1)) begin
                                            if (row == 1'(ROWS - 1)) begin
                                                state <= FRAME_END;
                                            end else begin
                                                row   <= 1'b1;
                                                state <= ROW_ADDR;
                                            end
                                        end else begin
                                            col <= col + 1'b1;
                                        end
                                    end
                                endcase
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_char_refresh.sv
// Directed bench for lcd_char_refresh: a 2x4 panel for init, refresh, write timing,
// blink/blank and reset, plus a 1x3 panel for range checking and single-row frames.
module tb_lcd_char_refresh;

    typedef logic [9:0][8:0] frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       ready, frame_done, lcd_rs, lcd_rw, lcd_en, lcd_n, lcd_p;
    logic [7:0] lcd_dat;

    logic       wr_en2 = 1'b0;
    logic [1:0] wr_addr2 = 2'd0;
    logic [7:0] wr_data2 = 8'h00;
    logic [1:0] mode2 = 2'b00;
    logic       ready2, frame_done2, rs2, rw2, en2, n2, p2;
    logic [7:0] dat2;

    int checks = 0;
    int passes = 0;

    logic [7:0] txt  [8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h77, 8'h78, 8'h79, 8'h7A};
    logic [7:0] txt2 [4] = '{8'h6B, 8'h6C, 8'h6D, 8'h55};
    logic [7:0] mbuf [8];

    logic [1:0] bl_mode  [14] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11,
                                  2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    bit         bl_blank [14] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0};

    logic [8:0] q1 [$];
    logic [8:0] q2 [$];
    logic       en_prev = 1'b0;
    logic       en2_prev = 1'b0;
    int         hi_len = 0;
    logic [8:0] hi_byte = 9'h0;

    lcd_char_refresh #(
        .STEP_CYCLES(2), .POWERUP_TICKS(4), .CLEAR_TICKS(2),
        .COLS(4), .ROWS(2), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mode(mode), .ready(ready), .frame_done(frame_done), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat), .LCD_N(lcd_n), .LCD_P(lcd_p)
    );

    lcd_char_refresh #(
        .STEP_CYCLES(2), .POWERUP_TICKS(4), .CLEAR_TICKS(2),
        .COLS(3), .ROWS(1), .BLINK_FRAMES(2)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .mode(mode2), .ready(ready2), .frame_done(frame_done2), .lcd_rs(rs2),
        .lcd_rw(rw2), .lcd_en(en2), .lcd_dat(dat2), .LCD_N(n2), .LCD_P(p2)
    );

    always #5 clk = ~clk;

    // Byte capture on lcd_en rise; every enable pulse must be one tick wide with a stable byte
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            q1.push_back({lcd_rs, lcd_dat});
            hi_len  = 1;
            hi_byte = {lcd_rs, lcd_dat};
        end else if (lcd_en) begin
            hi_len++;
        end else if (en_prev && rst_n) begin
            checks++;
            if (hi_len !== 2 || {lcd_rs, lcd_dat} !== hi_byte)
                $display("FAIL en_pulse: width %0d byte %h then %h, required width 2 and stable byte",
                         hi_len, hi_byte, {lcd_rs, lcd_dat});
            else
                passes++;
        end
        en_prev = lcd_en;
        if (en2 && !en2_prev)
            q2.push_back({rs2, dat2});
        en2_prev = en2;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic frame_t exp_frame(input bit blank);
        frame_t f;
        f[0] = 9'h080;
        f[5] = 9'h0C0;
        for (int i = 0; i < 4; i++) begin
            f[1 + i] = {1'b1, blank ? 8'h20 : mbuf[i]};
            f[6 + i] = {1'b1, blank ? 8'h20 : mbuf[4 + i]};
        end
        return f;
    endfunction

    task automatic get_frame(output frame_t f);
        int n = 0;
        f = '1;
        step(1);
        while (frame_done !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1)
            $display("FAIL frame_done_wait: frame_done %b, required 1 within 100 clk", frame_done);
        else
            passes++;
        for (int i = 0; i < 10 && q1.size() > 0; i++)
            f[i] = q1.pop_front();
        q1.delete();
    endtask

    // Releases reset and follows the init sequence up to ready, optionally loading text
    task automatic do_init(input bit load);
        bit          idle_ok = 1'b1;
        logic [35:0] cmds = '1;
        q1.delete();
        q2.delete();
        for (int i = 0; i < 8; i++)
            mbuf[i] = load ? txt[i] : 8'h20;
        rst_n = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            if (load && n <= 8) begin
                wr_en = 1'b1; wr_addr = 3'(n - 1); wr_data = txt[n - 1];
            end else begin
                wr_en = 1'b0;
            end
            if (load && n <= 4) begin
                wr_en2 = 1'b1; wr_addr2 = 2'(n - 1); wr_data2 = txt2[n - 1];
            end else begin
                wr_en2 = 1'b0;
            end
            step(1);
            if (n <= 8 && {lcd_en, lcd_rs, lcd_dat, ready} !== 11'h0)
                idle_ok = 1'b0;
            if (n == 10) begin
                checks++;
                if ({lcd_en, lcd_rs, lcd_dat} !== {1'b0, 1'b0, 8'h38})
                    $display("FAIL cmd_setup: en/rs/dat %b/%b/%h, required 0/0/38", lcd_en, lcd_rs, lcd_dat);
                else
                    passes++;
            end
            if (n == 12) begin
                checks++;
                if (lcd_en !== 1'b1)
                    $display("FAIL cmd_pulse: lcd_en %b, required 1", lcd_en);
                else
                    passes++;
            end
            if (n == 35) begin
                checks++;
                if (ready !== 1'b0)
                    $display("FAIL ready_early: ready %b at clk 35, required 0", ready);
                else
                    passes++;
            end
        end
        checks++;
        if (ready !== 1'b1)
            $display("FAIL ready_rise: ready %b at clk 36, required 1", ready);
        else
            passes++;
        checks++;
        if (idle_ok !== 1'b1)
            $display("FAIL powerup_idle: outputs moved during power-up wait, required idle");
        else
            passes++;
        if (q1.size() == 4)
            cmds = {q1[0], q1[1], q1[2], q1[3]};
        checks++;
        if (cmds !== {9'h038, 9'h00C, 9'h006, 9'h001})
            $display("FAIL init_cmds: got %h (%0d bytes), required 038 00c 006 001", cmds, q1.size());
        else
            passes++;
        q1.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_dat, ready, frame_done, lcd_n, lcd_p} !== 14'b000_00000000_0001)
            $display("FAIL reset_values: en/rs/rw=%b%b%b dat=%h ready=%b fd=%b N/P=%b%b, required 000 00 0 0 01",
                     lcd_en, lcd_rs, lcd_rw, lcd_dat, ready, frame_done, lcd_n, lcd_p);
        else
            passes++;
        do_init(1'b1);
    endtask

    task automatic test_refresh;
        frame_t       f = '1;
        logic [107:0] got2 = '1;
        step(60);
        checks++;
        if (frame_done !== 1'b0)
            $display("FAIL frame_done_early: frame_done %b at 60 clk after ready, required 0", frame_done);
        else
            passes++;
        step(1);
        checks++;
        if (frame_done !== 1'b1)
            $display("FAIL frame_done_timing: frame_done %b at 61 clk after ready, required 1", frame_done);
        else
            passes++;
        for (int i = 0; i < 10 && q1.size() > 0; i++)
            f[i] = q1.pop_front();
        q1.delete();
        checks++;
        if (f !== exp_frame(1'b0))
            $display("FAIL first_frame: got %h required %h", f, exp_frame(1'b0));
        else
            passes++;
        step(1);
        checks++;
        if (frame_done !== 1'b0)
            $display("FAIL frame_done_width: frame_done %b one clk later, required 0", frame_done);
        else
            passes++;
        if (q2.size() >= 12)
            for (int i = 0; i < 12; i++)
                got2[107 - 9 * i -: 9] = q2[i];
        checks++;
        if (got2 !== {9'h038, 9'h00C, 9'h006, 9'h001, 9'h080, 9'h16B, 9'h16C, 9'h16D,
                      9'h080, 9'h16B, 9'h16C, 9'h16D})
            $display("FAIL small_panel: got %h, required init + two 1x3 frames 'klm'", got2);
        else
            passes++;
    endtask

    task automatic test_boundary;
        frame_t f;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h50;
        step(1);
        wr_en = 1'b0;
        step(52);
        // Next edge is the SETUP edge of cell 7
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h51;
        step(1);
        wr_en = 1'b0;
        checks++;
        if ({lcd_en, lcd_rs, lcd_dat} !== {1'b0, 1'b1, 8'h7A})
            $display("FAIL setup_old_value: en/rs/dat %b/%b/%h, required 0/1/7a", lcd_en, lcd_rs, lcd_dat);
        else
            passes++;
        mbuf[6] = 8'h50;
        get_frame(f);
        checks++;
        if (f !== exp_frame(1'b0))
            $display("FAIL same_edge_write: got %h required %h", f, exp_frame(1'b0));
        else
            passes++;
        mbuf[7] = 8'h51;
        get_frame(f);
        checks++;
        if (f !== exp_frame(1'b0))
            $display("FAIL next_frame_write: got %h required %h", f, exp_frame(1'b0));
        else
            passes++;
    endtask

    task automatic test_blink;
        frame_t f;
        for (int i = 0; i < 14; i++) begin
            step(10);
            mode = bl_mode[i];
            get_frame(f);
            checks++;
            if (f !== exp_frame(bl_blank[i]))
                $display("FAIL mode_frame_%0d: got %h required %h", i, f, exp_frame(bl_blank[i]));
            else
                passes++;
        end
    endtask

    task automatic test_reset_mid;
        frame_t f;
        int     n = 0;
        while (lcd_en !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (lcd_en !== 1'b1)
            $display("FAIL pulse_search: lcd_en %b, required a PULSE tick within 20 clk", lcd_en);
        else
            passes++;
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({lcd_en, lcd_rs, lcd_dat, ready, frame_done} !== 12'h0)
            $display("FAIL reset_mid: en/rs/dat/ready/fd %b/%b/%h/%b/%b, required all 0",
                     lcd_en, lcd_rs, lcd_dat, ready, frame_done);
        else
            passes++;
        step(1);
        mode = 2'b00;
        do_init(1'b0);
        get_frame(f);
        checks++;
        if (f !== exp_frame(1'b0))
            $display("FAIL buffer_reset_frame: got %h required %h", f, exp_frame(1'b0));
        else
            passes++;
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_boundary();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
